// File: rtl/alu_req_engine.sv
// Single-outstanding request engine wrapped around an external combinational ALU:
// registers operands on accept, captures the ALU result one cycle later, holds it until the response handshake.
module alu_req_engine #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [15:0]     req_a,
  input  logic [15:0]     req_b,
  input  logic            req_chain,
  input  logic [TAGW-1:0] req_tag,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [3:0]      alu_op,
  input  logic [15:0]     alu_c,
  input  logic            alu_cout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_c,
  output logic            rsp_cout,
  output logic [TAGW-1:0] rsp_tag,
  output logic [15:0]     rsp_count
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_capture;
  logic                w_rsp_done;

  logic [DATA_W-1:0]   r_alu_a_p0;
  logic [DATA_W-1:0]   r_alu_b_p0;
  logic [3:0]          r_alu_op_p0;
  logic [TAGW-1:0]     r_tag_p0;
  logic [DATA_W-1:0]   r_rsp_c_p1;
  logic                r_rsp_cout_p1;
  logic [TAGW-1:0]     r_rsp_tag_p1;
  logic [DATA_W-1:0]   r_last;
  logic [15:0]         r_count;

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_capture  = (r_state == ST_DRIVE);
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_nxt = ST_DRIVE;
      ST_DRIVE: w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // p0: operands launched to the ALU on accept; stay put until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a_p0  <= '0;
      r_alu_b_p0  <= '0;
      r_alu_op_p0 <= '0;
      r_tag_p0    <= '0;
    end else if (w_accept) begin
      r_alu_a_p0  <= req_chain ? r_last : req_a;
      r_alu_b_p0  <= req_b;
      r_alu_op_p0 <= req_op;
      r_tag_p0    <= req_tag;
    end
  end

  // p1: ALU result captured at the edge leaving DRIVE, held through RESP and IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_c_p1    <= '0;
      r_rsp_cout_p1 <= 1'b0;
      r_rsp_tag_p1  <= '0;
      r_last        <= '0;
    end else if (w_capture) begin
      r_rsp_c_p1    <= alu_c;
      r_rsp_cout_p1 <= alu_cout;
      r_rsp_tag_p1  <= r_tag_p0;
      r_last        <= alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           r_count <= '0;
    else if (w_rsp_done) r_count <= r_count + 16'd1;
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign alu_a     = r_alu_a_p0;
  assign alu_b     = r_alu_b_p0;
  assign alu_op    = r_alu_op_p0;
  assign rsp_c     = r_rsp_c_p1;
  assign rsp_cout  = r_rsp_cout_p1;
  assign rsp_tag   = r_rsp_tag_p1;
  assign rsp_count = r_count;

endmodule

// File: tb/tb_alu_req_engine.sv
// Bench for alu_req_engine: plays the combinational ALU, runs a vector table, corner sequences
// and random requests against a transaction-level model (last result, completion count).
module tb_alu_req_engine;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [15:0]     req_a, req_b;
  logic            req_chain;
  logic [TAGW-1:0] req_tag;
  logic [15:0]     alu_a, alu_b;
  logic [3:0]      alu_op;
  logic [15:0]     alu_c;
  logic            alu_cout;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_c;
  logic            rsp_cout;
  logic [TAGW-1:0] rsp_tag;
  logic [15:0]     rsp_count;

  always #5 clk = ~clk;

  alu_req_engine #(.TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_chain(req_chain), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_cout(rsp_cout), .rsp_tag(rsp_tag), .rsp_count(rsp_count)
  );

  // ALU behaviour: {cout, c}
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] d;
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd15: begin
        d = {a, a} << b[3:0];
        return {1'b0, d[31:16]};
      end
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_cout, alu_c} = alu_fn(alu_op, alu_a, alu_b);

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] m_last;
  logic [15:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic chain, input logic [TAGW-1:0] tag, input int hold,
                         output logic [15:0] got_a, output logic [15:0] got_c, output logic got_cout);
    logic [15:0] ea;
    logic [16:0] r;
    ea = chain ? m_last : a;
    r  = alu_fn(op, ea, b);
    req_op = op; req_a = a; req_b = b; req_chain = chain; req_tag = tag;
    req_valid = 1'b1;
    chk("ready_in_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, b);
    chk("alu_op", alu_op, op);
    chk("busy_after_accept", req_ready, 0);
    chk("no_early_rsp", rsp_valid, 0);
    got_a = alu_a;
    step();
    chk("rsp_valid_latency", rsp_valid, 1);
    chk("rsp_c", rsp_c, r[15:0]);
    chk("rsp_cout", rsp_cout, r[16]);
    chk("rsp_tag", rsp_tag, tag);
    got_c = rsp_c;
    got_cout = rsp_cout;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a = 16'($urandom);
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_c", rsp_c, r[15:0]);
      chk("hold_tag", rsp_tag, tag);
      chk("hold_not_ready", req_ready, 0);
      chk("hold_alu_a", alu_a, ea);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_last  = r[15:0];
    m_count = m_count + 16'd1;
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
    chk("rsp_count", rsp_count, m_count);
    chk("idle_hold_c", rsp_c, r[15:0]);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        chain;
    logic [3:0]  tag;
    logic [15:0] exp_alu_a;
    logic [15:0] exp_c;
    logic        exp_cout;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] ga, gc;
    logic        gco;

    tbl[0] = '{4'd0,  16'h1234, 16'h0007, 1'b1, 4'd1,  16'h0000, 16'h0007, 1'b0};
    tbl[1] = '{4'd0,  16'h0002, 16'h0003, 1'b0, 4'd5,  16'h0002, 16'h0005, 1'b0};
    tbl[2] = '{4'd1,  16'h7777, 16'h0001, 1'b1, 4'd6,  16'h0005, 16'h0004, 1'b1};
    tbl[3] = '{4'd0,  16'h8000, 16'h8000, 1'b0, 4'd7,  16'h8000, 16'h0000, 1'b1};
    tbl[4] = '{4'd1,  16'h0000, 16'hFFFF, 1'b0, 4'd8,  16'h0000, 16'h0001, 1'b0};
    tbl[5] = '{4'd4,  16'hAAAA, 16'h5555, 1'b0, 4'd9,  16'hAAAA, 16'hFFFF, 1'b0};
    tbl[6] = '{4'd15, 16'h8001, 16'h0001, 1'b0, 4'd14, 16'h8001, 16'h0003, 1'b0};
    tbl[7] = '{4'd0,  16'h0000, 16'hFFFD, 1'b1, 4'd15, 16'h0003, 16'h0000, 1'b1};

    reset = 1'b1; req_valid = 1'b1; req_op = 4'd0; req_a = 16'h1111; req_b = 16'h2222;
    req_chain = 1'b0; req_tag = 4'hA; rsp_ready = 1'b1;
    step();
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    step();
    chk("rst_no_accept", req_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_count", rsp_count, 0);
    m_last = 16'h0; m_count = 16'h0;

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chain, tbl[i].tag, i % 3, ga, gc, gco);
      chk("tbl_alu_a", ga, tbl[i].exp_alu_a);
      chk("tbl_c", gc, tbl[i].exp_c);
      chk("tbl_cout", gco, tbl[i].exp_cout);
    end
    chk("tbl_count", rsp_count, 16'd8);

    // held req_valid across a stalled response: second request accepted exactly once
    req_op = 4'd0; req_a = 16'd10; req_b = 16'd20; req_chain = 1'b0; req_tag = 4'd3;
    req_valid = 1'b1;
    step();
    req_op = 4'd4; req_a = 16'hF0F0; req_b = 16'h0FF0; req_tag = 4'd4;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_not_ready", req_ready, 0);
      chk("bp_c", rsp_c, 16'd30);
      chk("bp_tag", rsp_tag, 4'd3);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_drop", rsp_valid, 0);
    chk("bp_ready", req_ready, 1);
    chk("bp_alu_a_kept", alu_a, 16'd10);
    step();
    req_valid = 1'b0;
    chk("bp_second_accept", req_ready, 0);
    chk("bp_second_alu_a", alu_a, 16'hF0F0);
    step();
    chk("bp_second_c", rsp_c, 16'hFF00);
    chk("bp_second_tag", rsp_tag, 4'd4);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    chk("bp_single_accept", req_ready, 1);
    chk("bp_no_extra_rsp", rsp_valid, 0);
    m_last = 16'hFF00; m_count = m_count + 16'd2;
    chk("bp_count", rsp_count, m_count);

    // reset during DRIVE discards the request
    req_op = 4'd0; req_a = 16'd1; req_b = 16'd1; req_tag = 4'd2; req_valid = 1'b1;
    step();
    req_valid = 1'b0; reset = 1'b1; rsp_ready = 1'b1;
    step();
    reset = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 0);
    chk("rd_ready", req_ready, 1);
    chk("rd_count", rsp_count, 0);
    chk("rd_alu_a", alu_a, 0);
    step();
    chk("rd_still_no_rsp", rsp_valid, 0);
    chk("rd_count_kept", rsp_count, 0);
    rsp_ready = 1'b0;
    m_last = 16'h0; m_count = 16'h0;
    run_req(4'd0, 16'hBEEF, 16'd9, 1'b1, 4'd11, 1, ga, gc, gco);
    chk("rd_chain_zero", ga, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      run_req(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              4'($urandom), int'($urandom_range(0, 3)), ga, gc, gco);
    end

    // counter wrap: preload near the top instead of 65535 real completions
    force dut.r_count = 16'hFFFF;
    step();
    release dut.r_count;
    step();
    chk("wrap_preload", rsp_count, 16'hFFFF);
    m_count = 16'hFFFF;
    run_req(4'd3, 16'h00F0, 16'h0F00, 1'b0, 4'd12, 0, ga, gc, gco);
    chk("wrap_zero", rsp_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
